// File: rtl/risc32_pkg.sv
// Shared Risc32 types and constants used by the fetch stage.
package risc32_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned XLEN    = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with synchronous flush and a registered head.
// While empty, the head output keeps showing the last entry presented.
module fetch_fifo
    import risc32_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    hold_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     count_q;
    logic            do_pop;

    assign do_pop = pop && (count_q != '0);
    assign count  = count_q;
    assign head   = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            hold_q <= head;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                case ({push, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Risc32 instruction fetch: PC, single outstanding imem request, prefetch FIFO, redirect flush.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushes counters.
module fetch_unit
    import risc32_pkg::*;
#(
    parameter int unsigned      DEPTH        = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_valid,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [XLEN-1:0]     instr_pc,
    input  logic                instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_flushes
`endif
);

    localparam int unsigned     CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, req_pc_q;
    logic             inflight_q, started_q;
    logic [CW-1:0]    count;
    logic [CW:0]      occupancy;
    logic             issue, push, pop;
    fetch_entry_t     push_data, head;

    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

    // started_q holds off the first request until the first edge after reset release.
    assign issue     = !rst && started_q && !redirect && (occupancy < DEPTH_LIM);
    assign push      = imem_valid && inflight_q && !redirect;
    assign pop       = instr_valid && instr_ready;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    assign push_data = '{instr: imem_rdata, pc: req_pc_q};

    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // Fixed one-cycle memory latency: whatever was in flight resolves this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_VECTOR;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            started_q  <= 1'b1;
            if (issue) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_flushes_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns 0x100 + addr/4 one cycle after each request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    int checks = 0;
    int errors = 0;
    int nreq;
    logic [31:0] exp_pc [6];

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH        (4),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushes (perf_flushes)
`endif
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: sample the request, answer it just after the edge, return at negedge + 1.
    task automatic step();
        logic        req;
        logic [31:0] addr;
        #1;
        req  = imem_req;
        addr = imem_addr;
        @(posedge clk);
        #1;
        imem_valid = req;
        imem_rdata = word(addr);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_rdata = '0; imem_valid = 1'b0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        step(); step();
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk32("rst_instr", instr, 32'h0);
        chk32("rst_pc", instr_pc, 32'h0);

        // Reset stream
        rst = 1'b0; instr_ready = 1'b1;
        step();
        chk1("s_req1", imem_req, 1'b1);
        chk32("s_addr1", imem_addr, 32'h0);
        chk1("s_valid1", instr_valid, 1'b0);
        step();
        chk1("s_valid2", instr_valid, 1'b0);
        step();
        chk1("s_valid3", instr_valid, 1'b1);
        chk32("s_pc0", instr_pc, 32'h0);
        chk32("s_ins0", instr, 32'h100);
        for (int k = 1; k < 4; k++) begin
            step();
            chk1("s_valid", instr_valid, 1'b1);
            chk32("s_pc", instr_pc, 32'(4 * k));
            chk32("s_ins", instr, 32'h100 + 32'(k));
        end

        // Asynchronous reset with a stream running, then backpressure
        rst = 1'b1;
        #1;
        chk1("ar_valid", instr_valid, 1'b0);
        chk1("ar_req", imem_req, 1'b0);
        chk32("ar_instr", instr, 32'h0);
        chk32("ar_pc", instr_pc, 32'h0);
        step();
        rst = 1'b0; instr_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) begin
                imem_valid = 1'b1;  // spurious response, nothing outstanding
                imem_rdata = 32'hBAD;
            end
            step();
            if (imem_req) begin
                chk32("bp_addr", imem_addr, 32'(4 * nreq));
                nreq++;
            end
        end
        chk32("bp_nreq", 32'(nreq), 32'd4);
        chk1("bp_req_stall", imem_req, 1'b0);
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        instr_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk1("bp_valid", instr_valid, 1'b1);
            chk32("bp_pc", instr_pc, exp_pc[j]);
            chk32("bp_ins", instr, word(exp_pc[j]));
            if (j == 1) begin
                chk1("bp_resume_req", imem_req, 1'b1);
                chk32("bp_resume_addr", imem_addr, 32'h10);
            end
            step();
        end

        // Redirect with three entries buffered
        rst = 1'b1;
        step();
        rst = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        redirect = 1'b1; redirect_pc = 32'h36;
        #1;
        chk1("rd_noreq", imem_req, 1'b0);
        chk32("rd_pc_before", instr_pc, 32'h0);
        step();
        redirect = 1'b0;
        #1;
        chk1("rd_valid1", instr_valid, 1'b0);
        chk1("rd_req1", imem_req, 1'b1);
        chk32("rd_addr1", imem_addr, 32'h34);
        instr_ready = 1'b1;
        step();
        chk1("rd_valid2", instr_valid, 1'b0);
        step();
        chk1("rd_valid3", instr_valid, 1'b1);
        chk32("rd_pc3", instr_pc, 32'h34);
        chk32("rd_ins3", instr, 32'h10D);
        step();
        chk32("rd_pc4", instr_pc, 32'h38);
        chk32("rd_ins4", instr, 32'h10E);

        // Redirect coincident with a response carrying 0xDEAD
        chk1("dd_resp_present", imem_valid, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h200; imem_rdata = 32'hDEAD;
        step();
        redirect = 1'b0;
        #1;
        chk1("dd_valid1", instr_valid, 1'b0);
        chk32("dd_addr1", imem_addr, 32'h200);
        chk1("dd_nodead", instr == 32'hDEAD, 1'b0);
        step();
        chk1("dd_nodead", instr == 32'hDEAD, 1'b0);
        step();
        chk32("dd_pc3", instr_pc, 32'h200);
        chk32("dd_ins3", instr, 32'h180);
        step();
        chk32("dd_pc4", instr_pc, 32'h204);
        chk1("dd_nodead", instr == 32'hDEAD, 1'b0);

        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        #1;
        chk1("pw_req", imem_req, 1'b1);
        chk32("pw_addr", imem_addr, 32'hFFFF_FFF8);
        step();
        step();
        chk32("pw_pc0", instr_pc, 32'hFFFF_FFF8);
        chk32("pw_ins0", instr, 32'h4000_00FE);
        step();
        chk32("pw_pc1", instr_pc, 32'hFFFF_FFFC);
        chk32("pw_ins1", instr, 32'h4000_00FF);
        step();
        chk32("pw_pc2", instr_pc, 32'h0);
        chk32("pw_ins2", instr, 32'h100);

        // Reset with two entries buffered
`ifdef FETCH_PERF_EN
        chk32("pf_flushes", perf_flushes, 32'd3);
        chk1("pf_fetched_nz", perf_fetched != 32'd0, 1'b1);
`endif
        instr_ready = 1'b0;
        step();
        chk1("mr_valid", instr_valid, 1'b1);
        chk32("mr_head", instr_pc, 32'h0);
        rst = 1'b1;
        #1;
        chk1("mr_valid_rst", instr_valid, 1'b0);
        chk1("mr_req_rst", imem_req, 1'b0);
        chk32("mr_pc_rst", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk32("mr_pf_fetched", perf_fetched, 32'd0);
        chk32("mr_pf_flushes", perf_flushes, 32'd0);
`endif
        imem_valid = 1'b1; imem_rdata = 32'hBAD;
        step();
        step();
        rst = 1'b0; instr_ready = 1'b1;
        step();
        chk1("mr_req1", imem_req, 1'b1);
        chk32("mr_addr1", imem_addr, 32'h0);
        step();
        step();
        chk1("mr_valid3", instr_valid, 1'b1);
        chk32("mr_pc3", instr_pc, 32'h0);
        chk32("mr_ins3", instr, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
